// File: rtl/pipeline_register.sv
// pipeline_register
// Single-stage valid/ready register slice with a skid entry. Data, valid and
// ready are all driven from flops, so the producer and consumer timing paths
// are fully decoupled while one word per cycle still flows.
module pipeline_register #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] skid;
   logic                  in_xfer;
   logic                  out_xfer;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   // Occupancy FSM; out_data is the main register and skid catches the word
   // accepted while the consumer stalls, so in_ready can stay registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         out_data  <= '0;
         skid      <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  state     <= BUSY;
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b1;
               end
            end
            BUSY: begin
               if (in_xfer && out_xfer) begin
                  // Pass-through: occupancy stays at one, main takes new word.
                  out_data <= in_data;
               end else if (in_xfer) begin
                  state    <= FULL;
                  skid     <= in_data;
                  in_ready <= 1'b0;
               end else if (out_xfer) begin
                  // out_data keeps the last word; only valid drops.
                  state     <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain path matters.
               if (out_xfer) begin
                  state    <= BUSY;
                  out_data <= skid;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_register.sv
// tb_pipeline_register
// Directed scenarios plus a randomized run, all checked against a queue model
// of the two-entry buffer (occupancy = queue length, head = presented word).
module tb_pipeline_register;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

   always #5 clk = ~clk;

   pipeline_register #(.DATA_WIDTH(W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: FIFO of stored words, capacity two.
   logic [W-1:0] mq[$];
   logic [W-1:0] m_last;
   bit           m_acc;
   logic [W-1:0] dut_out[$];
   logic [W-1:0] ref_out[$];

   // Advance one cycle: log DUT output transfer, update model, land on negedge.
   task automatic step();
      bit iv;
      bit ov;
      if (out_valid === 1'b1 && out_ready) dut_out.push_back(out_data);
      iv = in_valid && (mq.size() < 2);
      ov = out_ready && (mq.size() > 0);
      if (ov) ref_out.push_back(mq.pop_front());
      if (iv) mq.push_back(in_data);
      if (mq.size() > 0) m_last = mq[0];
      m_acc = iv;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      mq.delete();
      m_last = '0;
   endtask

   task automatic test_reset();
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      reset_n   = 1'b1;
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_simple();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hA5A5_0001;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || in_ready !== 1'b1) begin
         errors++; $display("FAIL simple_latency: got v=%b d=%h r=%b want v=1 d=a5a50001 r=1", out_valid, out_data, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || dut_out.size() != 1 || dut_out[$] !== 32'hA5A5_0001) begin
         errors++; $display("FAIL simple_consume: got v=%b n=%0d want v=0 n=1 word a5a50001", out_valid, dut_out.size());
      end
   endtask

   task automatic test_backpressure();
      int n0;
      n0 = dut_out.size();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hDEAD_BEEF;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=deadbeef", i, out_valid, out_data);
         end
         step();
      end
      out_ready = 1'b1;
      repeat (3) step();
      checks++;
      if (dut_out.size() != n0 + 1 || dut_out[$] !== 32'hDEAD_BEEF || out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_once: got n=%0d v=%b want n=%0d v=0", dut_out.size(), out_valid, n0 + 1);
      end
   endtask

   task automatic test_skid();
      int n0;
      n0 = dut_out.size();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h1;
      step();
      in_data = 32'h2;
      step();
      in_data = 32'h3;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (in_ready !== 1'b0 || out_data !== 32'h1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL skid_full[%0d]: got r=%b d=%h want r=0 d=00000001", i, in_ready, out_data);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_data !== 32'h2) begin
         errors++; $display("FAIL skid_drain: got r=%b d=%h want r=1 d=00000002", in_ready, out_data);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_data !== 32'h3 || out_valid !== 1'b1) begin
         errors++; $display("FAIL skid_third: got v=%b d=%h want v=1 d=00000003", out_valid, out_data);
      end
      step();
      checks++;
      if (dut_out.size() != n0 + 3 || dut_out[n0] !== 32'h1 || dut_out[n0+1] !== 32'h2 || dut_out[n0+2] !== 32'h3) begin
         errors++; $display("FAIL skid_order: got n=%0d want n=%0d sequence 1,2,3", dut_out.size(), n0 + 3);
      end
   endtask

   task automatic test_streaming();
      int n0;
      n0 = dut_out.size();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = W'(i);
         checks++;
         if (in_ready !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
            errors++; $display("FAIL stream_flow[%0d]: got r=%b v=%b want r=1 v=1", i, in_ready, out_valid);
         end
         step();
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (dut_out.size() != n0 + 16) begin
         errors++; $display("FAIL stream_count: got %0d want %0d", dut_out.size() - n0, 16);
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut_out[n0+i] !== W'(i)) begin
               errors++; $display("FAIL stream_word[%0d]: got %h want %h", i, dut_out[n0+i], W'(i));
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      int n0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h1234_5678;
      step();
      in_valid = 1'b0;
      step();
      n0 = dut_out.size();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hCAFE_0000;
      step();
      in_valid = 1'b0;
      checks++;
      if (dut_out.size() != n0 + 1 || dut_out[$] !== 32'h1234_5678 || out_data !== 32'hCAFE_0000 ||
          out_valid !== 1'b1 || in_ready !== 1'b1) begin
         errors++; $display("FAIL simul_busy: got v=%b r=%b d=%h want v=1 r=1 d=cafe0000 after 12345678", out_valid, in_ready, out_data);
      end
      step();
      checks++;
      if (dut_out[$] !== 32'hCAFE_0000 || out_valid !== 1'b0) begin
         errors++; $display("FAIL simul_next: got %h v=%b want cafe0000 v=0", dut_out[$], out_valid);
      end
   endtask

   task automatic test_async_reset();
      int n0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hAAAA_0001;
      step();
      in_data = 32'hAAAA_0002;
      step();
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
         errors++; $display("FAIL async_reset: got v=%b r=%b d=%h want v=0 r=1 d=0", out_valid, in_ready, out_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      n0 = dut_out.size();
      out_ready = 1'b1;
      repeat (4) step();
      checks++;
      if (dut_out.size() != n0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL async_stale: got %0d words v=%b want 0 words v=0", dut_out.size() - n0, out_valid);
      end
   endtask

   task automatic test_random();
      in_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!in_valid || m_acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         checks++;
         if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) || out_data !== m_last) begin
            errors++; $display("FAIL rand_state[%0d]: got v=%b r=%b d=%h want v=%b r=%b d=%h", c,
                               out_valid, in_ready, out_data, mq.size() > 0, mq.size() < 2, m_last);
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
      checks++;
      if (dut_out.size() != ref_out.size()) begin
         errors++; $display("FAIL rand_count: got %0d want %0d", dut_out.size(), ref_out.size());
      end else begin
         for (int i = 0; i < dut_out.size(); i++) begin
            if (dut_out[i] !== ref_out[i]) begin
               checks++; errors++;
               $display("FAIL rand_order[%0d]: got %h want %h", i, dut_out[i], ref_out[i]);
            end
         end
      end
   endtask

   initial begin
      m_acc = 1'b0;
      test_reset();
      test_simple();
      test_backpressure();
      test_skid();
      test_streaming();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_register.md
# pipeline_register

Single-stage, full-throughput valid/ready pipeline register (skid-buffer style) inserted between a producer and a consumer to break timing paths on the data, valid and ready signals. Data accepted on the input handshake appears on the output one cycle later, in order, without loss or duplication. `in_ready` is registered, so there is no combinational path from `out_ready` to `in_ready` or from `in_valid` to `out_valid`. Internal storage is two entries: a main output register and a skid register.

## Interface
- `DATA_WIDTH`, default 32, payload width in bits.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: producer has a word on `in_data`.
- `in_ready` output 1: block can accept a word this cycle; registered.
- `in_data` input `DATA_WIDTH`: input payload.
- `out_valid` output 1: `out_data` holds a valid word; registered.
- `out_ready` input 1: consumer accepts the word this cycle.
- `out_data` output `DATA_WIDTH`: output payload; registered.

## Operation
- Input transfer occurs when `in_valid && in_ready` at a rising edge.
- Output transfer occurs when `out_valid && out_ready` at a rising edge.
- States:
  - EMPTY: `out_valid=0`, `in_ready=1`.
  - BUSY: main register full, `out_valid=1`, `in_ready=1`.
  - FULL: main and skid registers full, `out_valid=1`, `in_ready=0`.
- EMPTY transitions:
  - Input transfer → BUSY, main ← `in_data`.
  - Otherwise stay in EMPTY.
- BUSY transitions:
  - Input and output transfer together → BUSY, main ← `in_data`.
  - Input transfer only → FULL, skid ← `in_data`.
  - Output transfer only → EMPTY.
  - Neither → hold.
- FULL transitions:
  - Output transfer → BUSY, main ← skid.
  - Otherwise hold. `in_valid` is ignored because `in_ready=0`.
- `out_data` always reflects the main register. It keeps its last value when `out_valid=0`.
- Words leave in strict arrival order. Every accepted word is presented exactly once.
- The producer must hold `in_valid` and `in_data` stable until accepted. The block does not check this.
- The block holds `out_valid` and `out_data` stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid=0`, `in_ready=1`, `out_data=0`, skid register = 0, state EMPTY.
- Reset takes effect immediately on assertion, without waiting for a clock edge.
- Reset asserted mid-operation discards all stored words.
- Latency: a word accepted at edge N drives `out_valid=1` and `out_data` after edge N, so it is consumable at edge N+1.
- Throughput: one word per cycle sustained when `out_ready=1` continuously. `in_ready` never drops in that case.
- Backpressure: with `out_ready=0`, at most two words are accepted. `in_ready` drops in the cycle after the second acceptance.
- `in_ready` rises one cycle after the output transfer that drains FULL.
- In BUSY, a simultaneous input and output transfer keeps the occupancy at one. The main register updates to the new word.

## Test plan
- Reset then simple transfer:
  - Stimulus: `out_ready=1`; present `in_valid=1`, `in_data=32'hA5A5_0001` for one cycle.
  - Required: after reset `out_valid=0`, `in_ready=1`, `out_data=0`. After the edge, `out_valid=1` and `out_data=32'hA5A5_0001`. It is consumed at the next edge, then `out_valid=0`.
- Backpressure hold:
  - Stimulus: `out_ready=0`; push `32'hDEAD_BEEF`; wait 3 cycles; then set `out_ready=1`.
  - Required: `out_valid=1` and `out_data=32'hDEAD_BEEF` hold stable while stalled. The word is transferred exactly once after release.
- Skid fill:
  - Stimulus: `out_ready=0`; push `32'h1`, then `32'h2`.
  - Required: `in_ready=0` after the second push, and a third word `32'h3` held on the input is not accepted.
  - Then set `out_ready=1`. Required output sequence: `32'h1`, `32'h2`, `32'h3` on consecutive cycles. `in_ready` returns to 1.
- Streaming:
  - Stimulus: `out_ready=1`; push incrementing values 0..15 back-to-back.
  - Required: 16 output transfers on consecutive cycles, in order, one cycle of latency, `in_ready` constantly 1.
- Simultaneous push/pop:
  - Stimulus: in BUSY holding `32'h1234_5678`, push `32'hCAFE_0000` while `out_ready=1`.
  - Required: `32'h1234_5678` transfers, the next output is `32'hCAFE_0000`, and the state remains BUSY.
- Asynchronous reset mid-stream:
  - Stimulus: assert `reset_n=0` between clock edges while in FULL.
  - Required: `out_valid=0`, `in_ready=1` and `out_data=0` immediately. No stale word appears after reset deasserts.
